// File: rtl/mcycle_contr_pkg.sv
// rtl/mcycle_contr_pkg.sv - shared opcodes, funct codes, aluop codes and FSM state encoding
package mcycle_contr_pkg;

  // Opcode field values handled by the controller
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct field values
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // aluop: what the main controller asks of the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // alu_c encoding shared with the single-cycle datapath
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
  } state_t;

endpackage

// File: rtl/mcycle_contr_aludec.sv
// rtl/mcycle_contr_aludec.sv - ALU decoder: aluop + funct -> alu_c
//   i_aluop : 00 add, 01 sub, 10 decode funct
//   i_funct : R-type funct field
//   o_alu_c : ALU operation select
module mcycle_contr_aludec
  import mcycle_contr_pkg::*;
(
  input  logic [1:0] i_aluop,
  input  logic [5:0] i_funct,
  output logic [3:0] o_alu_c
);

  always_comb begin
    o_alu_c = ALU_ADD;
    case (i_aluop)
      ALUOP_ADD: o_alu_c = ALU_ADD;
      ALUOP_SUB: o_alu_c = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          FN_ADD:  o_alu_c = ALU_ADD;
          FN_SUB:  o_alu_c = ALU_SUB;
          FN_AND:  o_alu_c = ALU_AND;
          FN_OR:   o_alu_c = ALU_OR;
          FN_SLT:  o_alu_c = ALU_SLT;
          default: o_alu_c = ALU_ADD;
        endcase
      end
      default: o_alu_c = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mcycle_contr.sv
// rtl/mcycle_contr.sv - multi-cycle MIPS-subset controller FSM with memory handshake
//   in : clk, rst_n (async, active-low), op_c, funct, zero, mem_rdy
//   out: mem_req, iord_c, mw_c, ir_we, pc_we, we_c, dest_reg_c, ext_c,
//        alusrca_c, alusrcb_c, result_c, pc_next_c, alu_c,
//        illegal_op (sticky), instr_cnt (retired instructions)
module mcycle_contr
  import mcycle_contr_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  op_c,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_rdy,
  output logic        mem_req,
  output logic        iord_c,
  output logic        mw_c,
  output logic        ir_we,
  output logic        pc_we,
  output logic        we_c,
  output logic        dest_reg_c,
  output logic        ext_c,
  output logic        alusrca_c,
  output logic [1:0]  alusrcb_c,
  output logic [1:0]  result_c,
  output logic [1:0]  pc_next_c,
  output logic [3:0]  alu_c,
  output logic        illegal_op,
  output logic [31:0] instr_cnt
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  w_aluop;
  logic        w_illegal_set;
  logic        w_retire;
  logic        r_illegal_op;
  logic [31:0] r_instr_cnt;
  logic [31:0] w_instr_cnt_nxt;

  mcycle_contr_aludec u_aludec (
    .i_aluop (w_aluop),
    .i_funct (funct),
    .o_alu_c (alu_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_FETCH;
      r_illegal_op <= 1'b0;
      r_instr_cnt  <= 32'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_instr_cnt <= w_instr_cnt_nxt;
      if (w_illegal_set) begin
        r_illegal_op <= 1'b1;
      end
    end
  end

  // Counter next value kept as a separate net so it can be preloaded for wrap tests
  assign w_instr_cnt_nxt = r_instr_cnt + {31'd0, w_retire};
  assign instr_cnt       = r_instr_cnt;
  assign illegal_op      = r_illegal_op;

  always_comb begin
    w_state_nxt   = r_state;
    w_aluop       = ALUOP_ADD;
    w_illegal_set = 1'b0;
    w_retire      = 1'b0;
    mem_req       = 1'b0;
    iord_c        = 1'b0;
    mw_c          = 1'b0;
    ir_we         = 1'b0;
    pc_we         = 1'b0;
    we_c          = 1'b0;
    dest_reg_c    = 1'b0;
    ext_c         = 1'b0;
    alusrca_c     = 1'b0;
    alusrcb_c     = 2'b00;
    result_c      = 2'b00;
    pc_next_c     = 2'b00;
    // Reset holds FETCH, so strobes are gated here to keep mem_req low during reset
    if (rst_n) begin
      case (r_state)
        S_FETCH: begin
          mem_req   = 1'b1;
          alusrcb_c = 2'b01;
          if (mem_rdy) begin
            ir_we       = 1'b1;
            pc_we       = 1'b1;
            w_state_nxt = S_DECODE;
          end
        end
        S_DECODE: begin
          alusrcb_c = 2'b11;
          case (op_c)
            OP_RTYPE:     w_state_nxt = S_EXEC;
            OP_LW, OP_SW: w_state_nxt = S_MEMADR;
            OP_BEQ:       w_state_nxt = S_BRANCH;
            OP_ADDI:      w_state_nxt = S_ADDIEX;
            OP_J:         w_state_nxt = S_JUMP;
            default: begin
              w_state_nxt   = S_FETCH;
              w_illegal_set = 1'b1;
            end
          endcase
        end
        S_MEMADR: begin
          alusrca_c   = 1'b1;
          alusrcb_c   = 2'b10;
          ext_c       = 1'b1;
          w_state_nxt = (op_c == OP_SW) ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          iord_c  = 1'b1;
          if (mem_rdy) w_state_nxt = S_MEMWB;
        end
        S_MEMWB: begin
          we_c        = 1'b1;
          result_c    = 2'b01;
          w_retire    = 1'b1;
          w_state_nxt = S_FETCH;
        end
        S_MEMWR: begin
          mem_req = 1'b1;
          iord_c  = 1'b1;
          mw_c    = 1'b1;
          if (mem_rdy) begin
            w_retire    = 1'b1;
            w_state_nxt = S_FETCH;
          end
        end
        S_EXEC: begin
          alusrca_c   = 1'b1;
          w_aluop     = ALUOP_FUNCT;
          w_state_nxt = S_ALUWB;
        end
        S_ALUWB: begin
          we_c        = 1'b1;
          dest_reg_c  = 1'b1;
          w_retire    = 1'b1;
          w_state_nxt = S_FETCH;
        end
        S_BRANCH: begin
          alusrca_c   = 1'b1;
          w_aluop     = ALUOP_SUB;
          pc_next_c   = 2'b01;
          pc_we       = zero;
          w_retire    = 1'b1;
          w_state_nxt = S_FETCH;
        end
        S_ADDIEX: begin
          alusrca_c   = 1'b1;
          alusrcb_c   = 2'b10;
          ext_c       = 1'b1;
          w_state_nxt = S_ADDIWB;
        end
        S_ADDIWB: begin
          we_c        = 1'b1;
          w_retire    = 1'b1;
          w_state_nxt = S_FETCH;
        end
        S_JUMP: begin
          pc_next_c   = 2'b10;
          pc_we       = 1'b1;
          w_retire    = 1'b1;
          w_state_nxt = S_FETCH;
        end
        default: w_state_nxt = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mcycle_contr.sv
// tb/tb_mcycle_contr.sv - scoreboard bench for the multi-cycle controller
module tb_mcycle_contr;

  localparam int F = 0, D = 1, MA = 2, MR = 3, MB = 4, MW = 5;
  localparam int EX = 6, AW = 7, BR = 8, AE = 9, AB = 10, J = 11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  op_c;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_rdy;
  logic        mem_req, iord_c, mw_c, ir_we, pc_we, we_c, dest_reg_c, ext_c, alusrca_c;
  logic [1:0]  alusrcb_c, result_c, pc_next_c;
  logic [3:0]  alu_c;
  logic        illegal_op;
  logic [31:0] instr_cnt;

  int checks = 0;
  int errors = 0;
  int n_step = 0;
  logic [31:0] exp_cnt = 32'd0;
  logic        exp_ill = 1'b0;

  typedef struct {
    int          id;
    int          st;
    logic [18:0] vec;
    logic [31:0] cnt;
    logic        ill;
  } exp_t;

  exp_t sb[$];

  mcycle_contr dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_c       (op_c),
    .funct      (funct),
    .zero       (zero),
    .mem_rdy    (mem_rdy),
    .mem_req    (mem_req),
    .iord_c     (iord_c),
    .mw_c       (mw_c),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .we_c       (we_c),
    .dest_reg_c (dest_reg_c),
    .ext_c      (ext_c),
    .alusrca_c  (alusrca_c),
    .alusrcb_c  (alusrcb_c),
    .result_c   (result_c),
    .pc_next_c  (pc_next_c),
    .alu_c      (alu_c),
    .illegal_op (illegal_op),
    .instr_cnt  (instr_cnt)
  );

  always #5 clk = ~clk;

  wire [18:0] obs = {mem_req, iord_c, mw_c, ir_we, pc_we, we_c, dest_reg_c, ext_c,
                     alusrca_c, alusrcb_c, result_c, pc_next_c, alu_c};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected control vector per state, from the state output table
  function automatic logic [18:0] ev(input int st, input logic rdy, input logic z, input logic [3:0] xalu);
    logic req, iord, mw, ir, pc, we, dst, ext, sa;
    logic [1:0] sb_, res, pn;
    logic [3:0] alu;
    {req, iord, mw, ir, pc, we, dst, ext, sa} = '0;
    sb_ = 2'b00; res = 2'b00; pn = 2'b00; alu = 4'b0010;
    case (st)
      F:  begin req = 1; sb_ = 2'b01; ir = rdy; pc = rdy; end
      D:  sb_ = 2'b11;
      MA: begin sa = 1; sb_ = 2'b10; ext = 1; end
      MR: begin req = 1; iord = 1; end
      MB: begin we = 1; res = 2'b01; end
      MW: begin req = 1; iord = 1; mw = 1; end
      EX: begin sa = 1; alu = xalu; end
      AW: begin we = 1; dst = 1; end
      BR: begin sa = 1; alu = 4'b0110; pn = 2'b01; pc = z; end
      AE: begin sa = 1; sb_ = 2'b10; ext = 1; end
      AB: we = 1;
      J:  begin pn = 2'b10; pc = 1; end
      default: ;
    endcase
    return {req, iord, mw, ir, pc, we, dst, ext, sa, sb_, res, pn, alu};
  endfunction

  // Called at posedge+1: drive this cycle's inputs and queue what the DUT should show
  task automatic step(input int st, input logic rdy, input logic z = 1'b0, input logic [3:0] xalu = 4'b0010);
    exp_t e;
    mem_rdy = rdy;
    zero    = z;
    e.id  = n_step++;
    e.st  = st;
    e.vec = ev(st, rdy, z, xalu);
    e.cnt = exp_cnt;
    e.ill = exp_ill;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check_eq($sformatf("ctl_s%0d_st%0d", e.id, e.st), {45'd0, obs}, {45'd0, e.vec});
      check_eq($sformatf("cnt_s%0d_st%0d", e.id, e.st), {31'd0, illegal_op, instr_cnt},
               {31'd0, e.ill, e.cnt});
    end
  end

  task automatic set_ins(input logic [5:0] op, input logic [5:0] fn);
    op_c  = op;
    funct = fn;
  endtask

  initial begin
    rst_n = 1'b0; op_c = 6'd0; funct = 6'd0; zero = 1'b0; mem_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req", {63'd0, mem_req}, 64'd0);
    check_eq("rst_pcwe_irwe", {62'd0, pc_we, ir_we}, 64'd0);
    check_eq("rst_mw_we", {62'd0, mw_c, we_c}, 64'd0);
    check_eq("rst_cnt_ill", {31'd0, illegal_op, instr_cnt}, 64'd0);
    rst_n = 1'b1;

    // R-type add, zero-wait memory
    set_ins(6'b000000, 6'b100000);
    step(F, 1); step(D, 1); step(EX, 1, 0, 4'b0010); step(AW, 1); exp_cnt++;
    // R-type sub
    set_ins(6'b000000, 6'b100010);
    step(F, 1); step(D, 1); step(EX, 1, 0, 4'b0110); step(AW, 1); exp_cnt++;
    // lw with 3 wait cycles in FETCH and MEMRD
    set_ins(6'b100011, 6'b000000);
    step(F, 0); step(F, 0); step(F, 0); step(F, 1); step(D, 1); step(MA, 1);
    step(MR, 0); step(MR, 0); step(MR, 0); step(MR, 1); step(MB, 1); exp_cnt++;
    // sw with one wait cycle
    set_ins(6'b101011, 6'b000000);
    step(F, 1); step(D, 1); step(MA, 0); step(MW, 0); step(MW, 1); exp_cnt++;
    // beq taken, then not taken
    set_ins(6'b000100, 6'b000000);
    step(F, 1); step(D, 1); step(BR, 1, 1); exp_cnt++;
    step(F, 1); step(D, 1); step(BR, 1, 0); exp_cnt++;
    // addi
    set_ins(6'b001000, 6'b000000);
    step(F, 1); step(D, 1); step(AE, 1); step(AB, 1); exp_cnt++;
    // jump with counter preloaded to all ones: must wrap to zero
    set_ins(6'b000010, 6'b000000);
    force dut.w_instr_cnt_nxt = 32'hFFFF_FFFF;
    step(F, 0);
    release dut.w_instr_cnt_nxt;
    exp_cnt = 32'hFFFF_FFFF;
    step(F, 1); step(D, 1); step(J, 1); exp_cnt = 32'd0;
    // illegal opcode: back to FETCH, sticky flag, no count
    set_ins(6'b111111, 6'b000000);
    step(F, 1); step(D, 1); exp_ill = 1'b1;
    set_ins(6'b000000, 6'b100000);
    step(F, 1); step(D, 1); step(EX, 1); step(AW, 1); exp_cnt++;
    // reset asserted during a MEMWR wait
    set_ins(6'b101011, 6'b000000);
    step(F, 1); step(D, 1); step(MA, 0);
    #1;
    check_eq("mw_pre", {62'd0, mw_c, mem_req}, 64'd3);
    #1 rst_n = 1'b0;
    #1;
    check_eq("mw_rst", {62'd0, mw_c, mem_req}, 64'd0);
    check_eq("cnt_rst", {31'd0, illegal_op, instr_cnt}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; exp_cnt = 32'd0; exp_ill = 1'b0;
    set_ins(6'b000000, 6'b100000);
    step(F, 1); step(D, 1); step(EX, 1); step(AW, 1); exp_cnt++;
    step(F, 0);

    repeat (2) @(negedge clk);
    check_eq("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcycle_contr.md
MCYCLE_CONTR -- requirements
Module: mcycle_contr

Interface
REQ-001 clk  in  1  system clock; all state changes on rising edge.
REQ-002 rst_n  in  1  reset, asynchronous, active-low.
REQ-003 op_c  in  6  opcode field of instruction register.
REQ-004 funct  in  6  funct field of instruction register.
REQ-005 zero  in  1  ALU zero flag.
REQ-006 mem_rdy  in  1  memory completion strobe for the current mem_req.
REQ-007 mem_req  out  1  memory access request, held until mem_rdy.
REQ-008 iord_c  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-009 mw_c / ir_we / pc_we  out  1 each  memory write, IR load, PC load strobes.
REQ-010 we_c / dest_reg_c / ext_c  out  1 each  regfile write, rd(1)/rt(0) select, sign extend.
REQ-011 alusrca_c  out  1  ALU A: 0 = PC, 1 = reg A; alusrcb_c  out  2  00 B, 01 const 4, 10 imm, 11 imm<<2.
REQ-012 result_c  out  2  writeback: 00 ALUOut, 01 memory data.
REQ-013 pc_next_c  out  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-014 alu_c  out  4  ALU operation, same encoding as the single-cycle datapath.
REQ-015 illegal_op  out  1  sticky flag: unsupported opcode decoded.
REQ-016 instr_cnt  out  32  retired-instruction count.

Function
REQ-017 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
REQ-018 FETCH: mem_req=1, iord_c=0, alusrca_c=0, alusrcb_c=01, aluop add; stay until mem_rdy; cycle with mem_rdy=1 asserts ir_we=1 and pc_we=1 (Mealy), next DECODE.
REQ-019 DECODE: alusrca_c=0, alusrcb_c=11, aluop add; next by op_c: 000000 EXEC, 100011/101011 MEMADR, 000100 BRANCH, 001000 ADDIEX, 000010 JUMP, else FETCH and illegal_op set.
REQ-020 MEMADR: alusrca_c=1, alusrcb_c=10, ext_c=1; next MEMRD (lw) or MEMWR (sw).
REQ-021 MEMRD: mem_req=1, iord_c=1; wait for mem_rdy, then MEMWB.
REQ-022 MEMWB: we_c=1, dest_reg_c=0, result_c=01; next FETCH.
REQ-023 MEMWR: mem_req=1, iord_c=1, mw_c=1; wait for mem_rdy, then FETCH.
REQ-024 EXEC: alusrca_c=1, alusrcb_c=00, aluop funct; next ALUWB. ALUWB: we_c=1, dest_reg_c=1, result_c=00; next FETCH.
REQ-025 BRANCH: alusrca_c=1, alusrcb_c=00, aluop sub, pc_next_c=01; pc_we=zero (Mealy); next FETCH.
REQ-026 ADDIEX: alusrca_c=1, alusrcb_c=10, ext_c=1, aluop add; next ADDIWB (we_c=1, dest_reg_c=0, result_c=00), then FETCH.
REQ-027 JUMP: pc_next_c=10, pc_we=1; next FETCH.
REQ-028 All strobes not listed for a state SHALL be 0; mw_c SHALL never assert outside MEMWR.
REQ-029 instr_cnt SHALL increment by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP; wraps 0xFFFFFFFF -> 0; illegal opcodes not counted.
REQ-030 mem_rdy outside FETCH/MEMRD/MEMWR SHALL be ignored; mem_rdy in the same cycle mem_req first rises SHALL complete the access (zero-wait memory).
REQ-031 illegal_op SHALL stay 1 until reset.

Reset
REQ-032 rst_n=0 SHALL immediately force state FETCH, instr_cnt=0, illegal_op=0, and pc_we, ir_we, mw_c, we_c, mem_req to 0, regardless of the current state, including mid memory wait.
REQ-033 First cycle after rst_n rises SHALL be FETCH with mem_req=1.

Structure
REQ-034 Opcode constants, state encoding and aluop codes SHALL live in the shared include alongside the funct codes.
REQ-035 ALU control SHALL be produced by one instance of the existing aludec (aluop, funct -> alu_c); the remainder is one state register plus next-state/output logic.

Verification
REQ-036 R-type add (op 000000, funct 100000), mem_rdy tied 1 -> FETCH,DECODE,EXEC,ALUWB; we_c=1, dest_reg_c=1 in ALUWB; instr_cnt 0->1.
REQ-037 lw, mem_rdy delayed 3 cycles in FETCH and in MEMRD -> mem_req held 4 cycles each; ir_we single pulse; MEMWB we_c=1, result_c=01.
REQ-038 beq with zero=1 then zero=0 -> pc_we=1, pc_next_c=01 in first BRANCH; pc_we=0 in second.
REQ-039 op 111111 -> DECODE to FETCH, illegal_op=1 sticky, instr_cnt unchanged.
REQ-040 rst_n low during MEMWR wait -> mw_c and mem_req drop same cycle; after release FETCH, instr_cnt=0.
REQ-041 instr_cnt preloaded to 0xFFFFFFFF via force, j (000010) retired -> instr_cnt=0, pc_next_c=10 in JUMP.
